// File: rtl/audio_fx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : audio_fx_fsm
// Brief    : Stereo audio effects engine. Captures one sample per slowclock
//            rise and applies the effect chosen by the latched select word.
// Revision : 1.0  initial release
// ============================================================================
module audio_fx_fsm #(
    parameter int W            = 16,
    parameter int CRUSH_BITS   = 6,
    parameter int CRUSH_FACTOR = 4,
    parameter int COMP_THRESH  = 8192,
    parameter int COMP_SHIFT   = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         slowclock,
    input  logic         comclock,
    input  logic [3:0]   sel,
    input  logic [W-1:0] leftin,
    input  logic [W-1:0] rightin,
    output logic [W-1:0] leftout,
    output logic [W-1:0] rightout
);

    localparam int                 c_DEC_W      = (CRUSH_FACTOR > 1) ? $clog2(CRUSH_FACTOR) : 1;
    localparam logic [c_DEC_W-1:0] c_DEC_LAST   = c_DEC_W'(CRUSH_FACTOR - 1);
    localparam logic [W-1:0]       c_CRUSH_MASK = {{CRUSH_BITS{1'b1}}, {(W-CRUSH_BITS){1'b0}}};
    localparam logic [W-1:0]       c_RES8_MASK  = {{8{1'b1}}, {(W-8){1'b0}}};
    localparam logic [W-1:0]       c_THRESH     = W'(COMP_THRESH);
    localparam logic [W-1:0]       c_MAG_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]       c_MAG_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic [3:0]         c_SEL_CRUSH  = 4'b0001;
    localparam logic [3:0]         c_SEL_MONO   = 4'b0010;
    localparam logic [3:0]         c_SEL_RES8   = 4'b0100;
    localparam logic [3:0]         c_SEL_COMP   = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_APPLY   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_slow_d;
    logic               r_com_d;
    logic [3:0]         r_sel;
    logic [3:0]         r_sel_cap;
    logic [c_DEC_W-1:0] r_dec;
    logic               r_crush_ok;
    logic [W-1:0]       r_in_l;
    logic [W-1:0]       r_in_r;
    logic [W-1:0]       r_res_l;
    logic [W-1:0]       r_res_r;
    logic               r_res_upd;

    logic               w_slow_rise;
    logic               w_com_rise;
    logic [3:0]         w_sel_now;
    logic [W-1:0]       w_mono;
    logic [W-1:0]       w_eff_l;
    logic [W-1:0]       w_eff_r;
    logic               w_eff_upd;

    // floor((a+b)/2) without a W+1-bit sum: halve each operand, add back the shared carry
    function automatic logic [W-1:0] f_mono(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a[W-1], a[W-1:1]} + {b[W-1], b[W-1:1]} + {{(W-1){1'b0}}, a[0] & b[0]};
    endfunction

    function automatic logic [W-1:0] f_compress(input logic [W-1:0] x);
        logic [W-1:0] mag;
        logic [W-1:0] red;
        if (x == c_MAG_MIN)
            mag = c_MAG_MAX;
        else if (x[W-1])
            mag = -x;
        else
            mag = x;
        if (mag > c_THRESH)
            red = c_THRESH + ((mag - c_THRESH) >> COMP_SHIFT);
        else
            red = mag;
        return x[W-1] ? -red : red;
    endfunction

    assign w_slow_rise = slowclock & ~r_slow_d;
    assign w_com_rise  = comclock & ~r_com_d;
    // a select word latched on the capture edge already applies to that sample
    assign w_sel_now   = w_com_rise ? sel : r_sel;
    assign w_mono      = f_mono(r_in_l, r_in_r);

    always_comb begin
        w_eff_l   = r_in_l;
        w_eff_r   = r_in_r;
        w_eff_upd = 1'b1;
        case (r_sel_cap)
            c_SEL_CRUSH: begin
                w_eff_l   = r_in_l & c_CRUSH_MASK;
                w_eff_r   = r_in_r & c_CRUSH_MASK;
                w_eff_upd = r_crush_ok;
            end
            c_SEL_MONO: begin
                w_eff_l = w_mono;
                w_eff_r = w_mono;
            end
            c_SEL_RES8: begin
                w_eff_l = r_in_l & c_RES8_MASK;
                w_eff_r = r_in_r & c_RES8_MASK;
            end
            c_SEL_COMP: begin
                w_eff_l = f_compress(r_in_l);
                w_eff_r = f_compress(r_in_r);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_slow_d   <= 1'b0;
            r_com_d    <= 1'b0;
            r_sel      <= 4'b0000;
            r_sel_cap  <= 4'b0000;
            r_dec      <= '0;
            r_crush_ok <= 1'b0;
            r_in_l     <= '0;
            r_in_r     <= '0;
            r_res_l    <= '0;
            r_res_r    <= '0;
            r_res_upd  <= 1'b0;
            leftout    <= '0;
            rightout   <= '0;
        end else begin
            r_slow_d <= slowclock;
            r_com_d  <= comclock;
            if (w_com_rise)
                r_sel <= sel;
            case (r_state)
                S_IDLE: begin
                    if (w_slow_rise) begin
                        r_in_l     <= leftin;
                        r_in_r     <= rightin;
                        r_sel_cap  <= w_sel_now;
                        r_crush_ok <= (r_dec == '0);
                        r_dec      <= (r_dec == c_DEC_LAST) ? '0 : r_dec + c_DEC_W'(1);
                        r_state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_res_l   <= w_eff_l;
                    r_res_r   <= w_eff_r;
                    r_res_upd <= w_eff_upd;
                    r_state   <= S_APPLY;
                end
                S_APPLY: begin
                    if (r_res_upd) begin
                        leftout  <= r_res_l;
                        rightout <= r_res_r;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_fx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_fx_fsm
// Brief    : Self-checking bench for audio_fx_fsm against an integer model.
// Revision : 1.0  initial release
// ============================================================================
module tb_audio_fx_fsm;

    localparam int W        = 16;
    localparam int CB       = 6;
    localparam int CF       = 4;
    localparam int THRESH   = 8192;
    localparam int CSHIFT   = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         slowclock = 1'b0;
    logic         comclock = 1'b0;
    logic [3:0]   sel = 4'b0000;
    logic [W-1:0] leftin = '0;
    logic [W-1:0] rightin = '0;
    logic [W-1:0] leftout;
    logic [W-1:0] rightout;

    int           vectors = 0;
    int           miscompares = 0;

    logic [W-1:0] exp_l = '0;
    logic [W-1:0] exp_r = '0;
    logic [3:0]   m_sel = 4'b0000;
    int           m_cnt = 0;

    logic [3:0]   sel_pool [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1111};

    audio_fx_fsm #(
        .W(W), .CRUSH_BITS(CB), .CRUSH_FACTOR(CF), .COMP_THRESH(THRESH), .COMP_SHIFT(CSHIFT)
    ) dut (
        .clock(clock), .reset(reset), .slowclock(slowclock), .comclock(comclock), .sel(sel),
        .leftin(leftin), .rightin(rightin), .leftout(leftout), .rightout(rightout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Model: values as plain integers, truncation expressed as floor to a multiple
    function automatic int floor_to(input int x, input int q);
        int m;
        m = x % q;
        if (m < 0) m += q;
        return x - m;
    endfunction

    function automatic int compress(input int x);
        int a;
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        if (a > THRESH) a = THRESH + (a - THRESH) / (1 << CSHIFT);
        return (x < 0) ? -a : a;
    endfunction

    task automatic model_apply(input logic [W-1:0] li, input logic [W-1:0] ri);
        int l, r, s, m, ol, orr;
        bit upd;
        l = int'($signed(li));
        r = int'($signed(ri));
        ol = l; orr = r; upd = 1'b1;
        case (m_sel)
            4'b0001: begin
                upd = (m_cnt % CF) == 0;
                ol  = floor_to(l, 1 << (W - CB));
                orr = floor_to(r, 1 << (W - CB));
            end
            4'b0010: begin
                s = l + r;
                m = s / 2;
                if (s < 0 && (s % 2) != 0) m = m - 1;
                ol = m; orr = m;
            end
            4'b0100: begin
                ol  = floor_to(l, 1 << (W - 8));
                orr = floor_to(r, 1 << (W - 8));
            end
            4'b1000: begin
                ol  = compress(l);
                orr = compress(r);
            end
            default: ;
        endcase
        m_cnt++;
        if (upd) begin
            exp_l = W'(ol);
            exp_r = W'(orr);
        end
    endtask

    task automatic model_reset();
        exp_l = '0; exp_r = '0; m_sel = 4'b0000; m_cnt = 0;
    endtask

    task automatic set_sel(input logic [3:0] v);
        @(negedge clock);
        sel = v; comclock = 1'b1;
        @(negedge clock);
        comclock = 1'b0;
        m_sel = v;
    endtask

    // One full sample; optionally latch a new select on the very same edge
    task automatic do_sample(input logic [W-1:0] l, input logic [W-1:0] r,
                             input bit latch, input logic [3:0] nsel);
        @(negedge clock);
        leftin = l; rightin = r; slowclock = 1'b1;
        if (latch) begin
            sel = nsel; comclock = 1'b1;
        end
        @(negedge clock);
        slowclock = 1'b0; comclock = 1'b0;
        leftin = W'($urandom); rightin = W'($urandom);
        if (latch) m_sel = nsel;
        check("hold_e0_l", leftout, exp_l);
        @(negedge clock);
        check("hold_e1_r", rightout, exp_r);
        @(negedge clock);
        model_apply(l, r);
        check("out_l", leftout, exp_l);
        check("out_r", rightout, exp_r);
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_l", leftout, exp_l);
        check("rst_r", rightout, exp_r);
        @(negedge clock);
        reset = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_sample();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clock);
        check("reset_l", leftout, 16'h0000);
        check("reset_r", rightout, 16'h0000);
        reset = 1'b1;

        // pass-through, then held across idle cycles
        set_sel(4'b0000);
        do_sample(16'h1234, 16'hFEDC, 1'b0, 4'b0000);
        check("pass_l", leftout, 16'h1234);
        check("pass_r", rightout, 16'hFEDC);
        repeat (5) @(negedge clock);
        check("pass_hold", leftout, 16'h1234);

        // bit crush from a fresh decimation count
        pulse_reset();
        set_sel(4'b0001);
        do_sample(16'h7FFF, 16'h7FFF, 1'b0, 4'b0000);
        check("crush_7fff", leftout, 16'h7C00);
        do_sample(16'h0123, 16'h4567, 1'b0, 4'b0000);
        do_sample(16'h4567, 16'h0123, 1'b0, 4'b0000);
        do_sample(16'h89AB, 16'hCDEF, 1'b0, 4'b0000);
        check("crush_held", leftout, 16'h7C00);
        do_sample(16'h8001, 16'h8001, 1'b0, 4'b0000);
        check("crush_8001", rightout, 16'h8000);
        for (int i = 0; i < 3; i++)
            do_sample(rand_sample(), rand_sample(), 1'b0, 4'b0000);

        // mono
        set_sel(4'b0010);
        do_sample(16'h7FFF, 16'h7FFF, 1'b0, 4'b0000);
        check("mono_max", leftout, 16'h7FFF);
        do_sample(16'h8000, 16'h8000, 1'b0, 4'b0000);
        check("mono_min", rightout, 16'h8000);
        do_sample(16'h0001, 16'hFFFE, 1'b0, 4'b0000);
        check("mono_floor", leftout, 16'hFFFF);

        // 8-bit resolution
        set_sel(4'b0100);
        do_sample(16'h12FF, 16'hFF80, 1'b0, 4'b0000);
        check("res8_l", leftout, 16'h1200);
        check("res8_r", rightout, 16'hFF00);

        // compressor
        set_sel(4'b1000);
        do_sample(16'd16384, 16'hC000, 1'b0, 4'b0000);
        check("comp_pos", leftout, 16'd10240);
        check("comp_neg", rightout, 16'hD800);
        do_sample(16'd100, 16'h8000, 1'b0, 4'b0000);
        check("comp_small", leftout, 16'd100);
        check("comp_most_neg", rightout, 16'hC801);

        // select changes without a command tick are ignored
        @(negedge clock);
        sel = 4'b0000;
        do_sample(16'd16384, 16'd50, 1'b0, 4'b0000);
        check("sel_nolatch", leftout, 16'd10240);

        // invalid select behaves as pass-through; latch on the capture edge
        do_sample(16'h4321, 16'h8765, 1'b1, 4'b0011);
        check("sel_invalid", leftout, 16'h4321);
        do_sample(16'h12FF, 16'h0000, 1'b1, 4'b0100);
        check("sel_same_edge", leftout, 16'h1200);

        // reset while the sample sits in CAPTURE
        @(negedge clock);
        leftin = 16'h5555; rightin = 16'hAAAA; slowclock = 1'b1;
        @(negedge clock);
        slowclock = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        check("midrst_l", leftout, 16'h0000);
        check("midrst_r", rightout, 16'h0000);
        repeat (3) @(negedge clock);
        check("midrst_held", leftout, 16'h0000);
        reset = 1'b1;
        do_sample(16'h2468, 16'h1357, 1'b0, 4'b0000);
        check("after_rst", leftout, 16'h2468);

        // randomized mix of selects, latching styles and sample data
        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 11);
            if (k < 7)
                set_sel(sel_pool[k]);
            else if (k == 7) begin
                @(negedge clock);
                sel = 4'($urandom);
            end
            if (k == 8)
                do_sample(rand_sample(), rand_sample(), 1'b1, sel_pool[$urandom_range(0, 6)]);
            else
                do_sample(rand_sample(), rand_sample(), 1'b0, 4'b0000);
            if (k == 9 && i % 4 == 0)
                pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
